// File: rtl/branch_resolver.sv
// Branch resolver: in-order FIFO of in-flight conditional branches, speculative GHR owner,
// predictor feedback and mispredict recovery. Optional counters: BRANCH_RESOLVER_STATS_EN.
module branch_resolver #(
    parameter int ADDR_WIDTH = 32,
    parameter int GHR_LEN    = 8,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_dec_valid,
    input  logic [ADDR_WIDTH-1:0] i_dec_pc,
    input  logic                  i_dec_prediction,
    output logic                  o_full,
    output logic [GHR_LEN-1:0]    o_ghr,
    input  logic                  i_ex_valid,
    input  logic                  i_ex_outcome,
    output logic                  o_fb_valid,
    output logic [ADDR_WIDTH-1:0] o_fb_pc,
    output logic                  o_fb_prediction,
    output logic                  o_fb_outcome,
    output logic                  o_mispredict,
    output logic                  o_err,
    output logic [31:0]           o_stat_branches,
    output logic [31:0]           o_stat_mispredicts
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [ADDR_WIDTH-1:0] pc_mem_r   [DEPTH];
    logic                  pred_mem_r [DEPTH];
    logic [GHR_LEN-1:0]    snap_mem_r [DEPTH];

    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic [GHR_LEN-1:0]    ghr_r;
    logic                  fb_valid_r;
    logic [ADDR_WIDTH-1:0] fb_pc_r;
    logic                  fb_pred_r;
    logic                  fb_outcome_r;
    logic                  mispredict_r;
    logic                  err_r;

    logic                  full_s;
    logic                  empty_s;
    logic                  resolve_s;
    logic                  mispred_s;
    logic                  push_s;
    logic                  proto_err_s;
    logic [ADDR_WIDTH-1:0] head_pc_s;
    logic                  head_pred_s;
    logic [GHR_LEN-1:0]    head_snap_s;
    logic [GHR_LEN-1:0]    ghr_nxt_s;
    logic [CNT_W-1:0]      count_nxt_s;

    // Decode of push/resolve/recovery for this cycle and next GHR/count values.
    always_comb begin
        full_s      = (count_r == DEPTH_C);
        empty_s     = (count_r == {CNT_W{1'b0}});
        head_pc_s   = pc_mem_r[rd_ptr_r];
        head_pred_s = pred_mem_r[rd_ptr_r];
        head_snap_s = snap_mem_r[rd_ptr_r];
        resolve_s   = i_ex_valid & ~empty_s;
        mispred_s   = resolve_s & (head_pred_s != i_ex_outcome);
        // A push while full only fits because a correct resolve frees the head slot.
        push_s      = i_dec_valid & ~mispred_s & (~full_s | resolve_s);
        proto_err_s = (i_dec_valid & full_s & ~i_ex_valid) | (i_ex_valid & empty_s);

        ghr_nxt_s = ghr_r;
        if (mispred_s) begin
            ghr_nxt_s = {head_snap_s[GHR_LEN-2:0], i_ex_outcome};
        end else if (push_s) begin
            ghr_nxt_s = {ghr_r[GHR_LEN-2:0], i_dec_prediction};
        end else begin
            ghr_nxt_s = ghr_r;
        end

        count_nxt_s = count_r;
        if (mispred_s) begin
            count_nxt_s = {CNT_W{1'b0}};
        end else if (push_s && !resolve_s) begin
            count_nxt_s = count_r + CNT_W'(1);
        end else if (resolve_s && !push_s) begin
            count_nxt_s = count_r - CNT_W'(1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Entry storage; contents are don't-care until pushed, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            pc_mem_r[wr_ptr_r]   <= i_dec_pc;
            pred_mem_r[wr_ptr_r] <= i_dec_prediction;
            snap_mem_r[wr_ptr_r] <= ghr_r;
        end
    end

    // Pointers, occupancy and speculative GHR.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            ghr_r    <= {GHR_LEN{1'b0}};
        end else begin
            count_r <= count_nxt_s;
            ghr_r   <= ghr_nxt_s;
            if (mispred_s) begin
                rd_ptr_r <= wr_ptr_r;
            end else begin
                if (resolve_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_W'(1);
                end
                if (push_s) begin
                    wr_ptr_r <= wr_ptr_r + PTR_W'(1);
                end
            end
        end
    end

    // Registered predictor feedback; payload holds while the strobe is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fb_valid_r   <= 1'b0;
            fb_pc_r      <= {ADDR_WIDTH{1'b0}};
            fb_pred_r    <= 1'b0;
            fb_outcome_r <= 1'b0;
            mispredict_r <= 1'b0;
        end else begin
            fb_valid_r   <= resolve_s;
            mispredict_r <= mispred_s;
            if (resolve_s) begin
                fb_pc_r      <= head_pc_s;
                fb_pred_r    <= head_pred_s;
                fb_outcome_r <= i_ex_outcome;
            end
        end
    end

    // Sticky protocol-error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (proto_err_s) begin
            err_r <= 1'b1;
        end
    end

`ifdef BRANCH_RESOLVER_STATS_EN
    logic [31:0] stat_br_r;
    logic [31:0] stat_mis_r;

    // Saturating resolve and mispredict counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_br_r  <= 32'h0000_0000;
            stat_mis_r <= 32'h0000_0000;
        end else begin
            if (resolve_s && (stat_br_r != 32'hFFFF_FFFF)) begin
                stat_br_r <= stat_br_r + 32'd1;
            end
            if (mispred_s && (stat_mis_r != 32'hFFFF_FFFF)) begin
                stat_mis_r <= stat_mis_r + 32'd1;
            end
        end
    end

    assign o_stat_branches    = stat_br_r;
    assign o_stat_mispredicts = stat_mis_r;
`else
    assign o_stat_branches    = 32'h0000_0000;
    assign o_stat_mispredicts = 32'h0000_0000;
`endif

    assign o_full          = full_s;
    assign o_ghr           = ghr_r;
    assign o_fb_valid      = fb_valid_r;
    assign o_fb_pc         = fb_pc_r;
    assign o_fb_prediction = fb_pred_r;
    assign o_fb_outcome    = fb_outcome_r;
    assign o_mispredict    = mispredict_r;
    assign o_err           = err_r;

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: directed test-plan steps plus random traffic
// checked against a queue-based reference model.
module tb_branch_resolver;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_dec_valid;
    logic [31:0] i_dec_pc;
    logic        i_dec_prediction;
    logic        o_full;
    logic [7:0]  o_ghr;
    logic        i_ex_valid;
    logic        i_ex_outcome;
    logic        o_fb_valid;
    logic [31:0] o_fb_pc;
    logic        o_fb_prediction;
    logic        o_fb_outcome;
    logic        o_mispredict;
    logic        o_err;
    logic [31:0] o_stat_branches;
    logic [31:0] o_stat_mispredicts;

    branch_resolver #(.ADDR_WIDTH(32), .GHR_LEN(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .i_dec_valid(i_dec_valid), .i_dec_pc(i_dec_pc), .i_dec_prediction(i_dec_prediction),
        .o_full(o_full), .o_ghr(o_ghr),
        .i_ex_valid(i_ex_valid), .i_ex_outcome(i_ex_outcome),
        .o_fb_valid(o_fb_valid), .o_fb_pc(o_fb_pc), .o_fb_prediction(o_fb_prediction),
        .o_fb_outcome(o_fb_outcome), .o_mispredict(o_mispredict), .o_err(o_err),
        .o_stat_branches(o_stat_branches), .o_stat_mispredicts(o_stat_mispredicts)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        pred;
        logic [7:0]  snap;
    } ent_t;

    ent_t        q[$];
    logic [7:0]  m_ghr;
    logic        m_err, m_fbv, m_fbp, m_fbo, m_mis;
    logic [31:0] m_fbpc, m_sb, m_sm;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ghr = 8'h00; m_err = 1'b0; m_fbv = 1'b0; m_fbp = 1'b0; m_fbo = 1'b0;
        m_mis = 1'b0; m_fbpc = 32'h0; m_sb = 32'h0; m_sm = 32'h0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".fb_valid"}, {31'h0, o_fb_valid}, {31'h0, m_fbv});
        chk({tag, ".mispredict"}, {31'h0, o_mispredict}, {31'h0, m_mis});
        chk({tag, ".fb_pc"}, o_fb_pc, m_fbpc);
        chk({tag, ".fb_pred"}, {31'h0, o_fb_prediction}, {31'h0, m_fbp});
        chk({tag, ".fb_outcome"}, {31'h0, o_fb_outcome}, {31'h0, m_fbo});
        chk({tag, ".ghr"}, {24'h0, o_ghr}, {24'h0, m_ghr});
        chk({tag, ".full"}, {31'h0, o_full}, {31'h0, (q.size() == 4)});
        chk({tag, ".err"}, {31'h0, o_err}, {31'h0, m_err});
`ifdef BRANCH_RESOLVER_STATS_EN
        chk({tag, ".stat_br"}, o_stat_branches, m_sb);
        chk({tag, ".stat_mis"}, o_stat_mispredicts, m_sm);
`else
        chk({tag, ".stat_br"}, o_stat_branches, 32'h0);
        chk({tag, ".stat_mis"}, o_stat_mispredicts, 32'h0);
`endif
    endtask

    // One clock cycle: drive inputs, advance the model by the behavioural rules, check after the edge.
    task automatic step(input string tag, input logic dv, input logic [31:0] pc, input logic pr,
                        input logic ev, input logic oc);
        ent_t h;
        ent_t e;
        logic full_m, empty_m, res;
        i_dec_valid = dv; i_dec_pc = pc; i_dec_prediction = pr;
        i_ex_valid = ev; i_ex_outcome = oc;
        full_m  = (q.size() == 4);
        empty_m = (q.size() == 0);
        res     = ev && !empty_m;
        m_fbv = 1'b0;
        m_mis = 1'b0;
        if (ev && empty_m) m_err = 1'b1;
        if (dv && full_m && !ev) m_err = 1'b1;
        if (res) begin
            h = q[0];
            m_fbv = 1'b1; m_fbpc = h.pc; m_fbp = h.pred; m_fbo = oc;
            m_mis = (h.pred != oc);
            if (m_sb != 32'hFFFF_FFFF) m_sb = m_sb + 32'd1;
            if (m_mis && m_sm != 32'hFFFF_FFFF) m_sm = m_sm + 32'd1;
            if (m_mis) begin
                q.delete();
                m_ghr = {h.snap[6:0], oc};
            end else begin
                void'(q.pop_front());
            end
        end
        if (!m_mis && dv && (!full_m || res)) begin
            e.pc = pc; e.pred = pr; e.snap = m_ghr;
            q.push_back(e);
            m_ghr = {m_ghr[6:0], pr};
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_dec_valid = 1'b0; i_dec_pc = 32'h0; i_dec_prediction = 1'b0;
        i_ex_valid = 1'b0; i_ex_outcome = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Drive the GHR to v from an empty FIFO by pushing its bits and resolving each correctly.
    task automatic set_ghr(input logic [7:0] v);
        logic prev;
        prev = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            step("set_ghr", 1'b1, 32'h1000 + 32'(i) * 32'd8, v[i], (i != 7), prev);
            prev = v[i];
        end
        step("set_ghr", 1'b0, 32'h0, 1'b0, 1'b1, prev);
    endtask

    initial begin
        do_reset();
        check_all("reset");
        chk("reset.ghr0", {24'h0, o_ghr}, 32'h0);

        // Plan 1: two pushes, correct resolve of the oldest.
        step("p1.push0", 1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
        step("p1.push1", 1'b1, 32'h108, 1'b0, 1'b0, 1'b0);
        chk("p1.ghr", {24'h0, o_ghr}, 32'h02);
        step("p1.res", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        chk("p1.fbv", {31'h0, o_fb_valid}, 32'h1);
        chk("p1.fbpc", o_fb_pc, 32'h100);
        chk("p1.mis", {31'h0, o_mispredict}, 32'h0);
        chk("p1.ghr2", {24'h0, o_ghr}, 32'h02);
        step("p1.res2", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        step("p1.idle", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Plan 2: mispredict recovery from GHR 0xA5.
        do_reset();
        set_ghr(8'hA5);
        chk("p2.ghrA5", {24'h0, o_ghr}, 32'hA5);
        step("p2.push0", 1'b1, 32'h200, 1'b1, 1'b0, 1'b0);
        chk("p2.ghr4B", {24'h0, o_ghr}, 32'h4B);
        step("p2.push1", 1'b1, 32'h208, 1'b1, 1'b0, 1'b0);
        chk("p2.ghr97", {24'h0, o_ghr}, 32'h97);
        step("p2.res", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("p2.mis", {31'h0, o_mispredict}, 32'h1);
        chk("p2.ghr4A", {24'h0, o_ghr}, 32'h4A);
        chk("p2.fbpc", o_fb_pc, 32'h200);
        step("p2.empty", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        chk("p2.nofb", {31'h0, o_fb_valid}, 32'h0);
        chk("p2.err", {31'h0, o_err}, 32'h1);

        // Plan 3: full, dropped push, push+correct resolve when full.
        do_reset();
        step("p3.a", 1'b1, 32'h400, 1'b1, 1'b0, 1'b0);
        step("p3.b", 1'b1, 32'h404, 1'b0, 1'b0, 1'b0);
        step("p3.c", 1'b1, 32'h408, 1'b1, 1'b0, 1'b0);
        step("p3.d", 1'b1, 32'h40C, 1'b1, 1'b0, 1'b0);
        chk("p3.full", {31'h0, o_full}, 32'h1);
        chk("p3.ghr", {24'h0, o_ghr}, 32'h0B);
        step("p3.drop", 1'b1, 32'h410, 1'b0, 1'b0, 1'b0);
        chk("p3.err", {31'h0, o_err}, 32'h1);
        chk("p3.ghr_kept", {24'h0, o_ghr}, 32'h0B);
        step("p3.pushres", 1'b1, 32'h414, 1'b0, 1'b1, 1'b1);
        chk("p3.full2", {31'h0, o_full}, 32'h1);
        chk("p3.fbpc", o_fb_pc, 32'h400);

        // Plan 4: mispredict discards a same-cycle push.
        do_reset();
        step("p4.push", 1'b1, 32'h2F0, 1'b0, 1'b0, 1'b0);
        step("p4.both", 1'b1, 32'h300, 1'b1, 1'b1, 1'b1);
        chk("p4.ghr", {24'h0, o_ghr}, 32'h01);
        chk("p4.mis", {31'h0, o_mispredict}, 32'h1);
        step("p4.empty", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        chk("p4.nofb", {31'h0, o_fb_valid}, 32'h0);

        // Plan 5: empty resolve error, then async reset with 3 in flight.
        do_reset();
        step("p5.empty", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("p5.err", {31'h0, o_err}, 32'h1);
        step("p5.a", 1'b1, 32'h500, 1'b1, 1'b0, 1'b0);
        step("p5.b", 1'b1, 32'h504, 1'b1, 1'b0, 1'b0);
        step("p5.c", 1'b1, 32'h508, 1'b1, 1'b0, 1'b0);
        i_dec_valid = 1'b0; i_ex_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("p5.rst_full", {31'h0, o_full}, 32'h0);
        chk("p5.rst_ghr", {24'h0, o_ghr}, 32'h0);
        chk("p5.rst_err", {31'h0, o_err}, 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("p5.after", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        chk("p5.nofb", {31'h0, o_fb_valid}, 32'h0);

        // Plan 6: 10 resolves with 3 mispredicts.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step("p6.push", 1'b1, 32'h600 + 32'(i) * 32'd4, 1'b1, 1'b0, 1'b0);
            step("p6.res", 1'b0, 32'h0, 1'b0, 1'b1, (i == 0 || i == 3 || i == 6) ? 1'b0 : 1'b1);
        end
`ifdef BRANCH_RESOLVER_STATS_EN
        chk("p6.br", o_stat_branches, 32'd10);
        chk("p6.mis", o_stat_mispredicts, 32'd3);
`else
        chk("p6.br", o_stat_branches, 32'd0);
        chk("p6.mis", o_stat_mispredicts, 32'd0);
`endif

        // Random traffic against the model.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            step("rand", ($urandom_range(0, 9) < 6), $urandom, $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 1) == 1), $urandom_range(0, 3) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Resolution-side counterpart of the branch predictor.
- Tracks every conditional branch from decode until execute resolves it, and owns the global history register (GHR) exported on branch_controls_ifc.
- Drives the predictor feedback channel (branch_result_ifc) and signals mispredicts to the hazard controller.
- In-flight entries live in an in-order FIFO; branches resolve strictly oldest-first.

Parameters:
ADDR_WIDTH  32  PC width in bits
GHR_LEN  8  global history length in bits
DEPTH  4  max in-flight unresolved branches (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
i_dec_valid  in  1  conditional branch leaving decode (push)
i_dec_pc  in  ADDR_WIDTH  branch PC
i_dec_prediction  in  1  predicted outcome, 1=TAKEN
o_full  out  1  FIFO holds DEPTH entries; hazard controller stalls decode
o_ghr  out  GHR_LEN  speculative GHR (curr_branch_controls.GHR)
i_ex_valid  in  1  oldest branch resolved this cycle
i_ex_outcome  in  1  actual outcome, 1=TAKEN
o_fb_valid  out  1  feedback strobe (ex_branch_result.valid)
o_fb_pc  out  ADDR_WIDTH  feedback PC
o_fb_prediction  out  1  prediction recorded at push
o_fb_outcome  out  1  actual outcome
o_mispredict  out  1  one-cycle pulse, prediction != outcome
o_err  out  1  sticky protocol-error flag
o_stat_branches  out  32  resolved-branch count (optional feature)
o_stat_mispredicts  out  32  mispredict count (optional feature)

Behaviour:
- Reset (async, rst=1):
  - FIFO empty; o_ghr=0; o_fb_valid=0; o_fb_pc=0; o_fb_prediction=0; o_fb_outcome=0; o_mispredict=0; o_err=0; stats=0.
- Entry contents: {pc, prediction, ghr_snapshot}. ghr_snapshot is o_ghr before this branch's speculative update.
- Push (i_dec_valid & ~o_full):
  - Entry is written at the clock edge.
  - At the same edge, o_ghr <= {o_ghr[GHR_LEN-2:0], i_dec_prediction}.
- Resolve (i_ex_valid & not empty):
  - Pop the head entry.
  - Next cycle (1-cycle latency, registered): o_fb_valid=1 and o_fb_pc, o_fb_prediction, o_fb_outcome are driven from the head entry and i_ex_outcome.
  - o_mispredict = (head.prediction != i_ex_outcome), registered alongside o_fb_valid.
  - o_fb_* hold their last value while o_fb_valid=0.
- Mispredict recovery (same edge as the pop):
  - Flush all younger entries; FIFO becomes empty.
  - o_ghr <= {head.ghr_snapshot[GHR_LEN-2:0], i_ex_outcome}.
- Correct prediction: o_ghr is unchanged by the resolve; a push in the same cycle still updates it.
- Simultaneous push and resolve:
  - Correct prediction: both happen. Count is unchanged, and pushing when full is allowed because a slot frees.
  - Mispredict: the push is discarded as wrong-path. GHR takes the recovery value and the FIFO is empty afterwards.
- o_full is combinational from count (count==DEPTH).
- Protocol errors, each setting o_err until reset:
  - Push while full with no resolve that cycle: push dropped, o_ghr unchanged.
  - Resolve while empty: ignored, o_fb_valid stays 0.
- Pointers:
  - log2(DEPTH)-bit read/write pointers wrap modulo DEPTH.
  - count is log2(DEPTH)+1 bits.
  - On flush, read pointer <= write pointer.
- Reset asserted mid-operation: all in-flight entries are discarded immediately, with no feedback emitted.

Optional Feature:
- Macro: BRANCH_RESOLVER_STATS_EN.
- Defined:
  - o_stat_branches increments on every valid resolve.
  - o_stat_mispredicts increments on every mispredict.
  - Both update at the resolve edge, saturate at 32'hFFFF_FFFF, and clear on reset.
- Undefined: the counter logic is not compiled; both ports are tied to 0.

Test Plan:
1. Reset, push PC 0x100 pred=1, push 0x108 pred=0 -> o_ghr=8'b0000_0010. Resolve 0x100 outcome=1 -> next cycle o_fb_valid=1, o_fb_pc=0x100, o_mispredict=0, o_ghr=8'b0000_0010.
2. o_ghr=8'hA5, push 0x200 pred=1 (o_ghr->8'h4B), push 0x208 pred=1 (8'h97). Resolve 0x200 outcome=0 -> o_mispredict=1, o_ghr=8'h4A, FIFO empty, 0x208 never fed back.
3. Push 4 branches (DEPTH=4) -> o_full=1. Push 5th with no resolve -> dropped, o_err=1. Push+correct resolve same cycle -> count stays 4, o_full=1.
4. One entry, pred=0. Same cycle push 0x300 and resolve outcome=1 -> push discarded, FIFO empty, o_ghr = snapshot<<1 | 1.
5. Resolve with FIFO empty -> o_fb_valid=0, o_err=1. Assert rst mid-stream with 3 entries -> o_full=0, o_ghr=0, o_err=0 immediately.
6. With BRANCH_RESOLVER_STATS_EN: 10 resolves, 3 mispredicts -> o_stat_branches=10, o_stat_mispredicts=3. Without the macro -> both 0.
